// File: rtl/reg_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// reg_seq_ctrl_pkg
// Shared definitions for the instruction sequencer:
//   - datapath widths (8-bit data, 3-bit selects, 8-bit PC)
//   - opcode encoding and sequencer state encoding
//   - instruction field bit positions for byte0 / byte1
//   - select constants (DSEL_NONE, SEL_DIN)
//   - is_fetch() helper identifying states that drive a memory request
// -----------------------------------------------------------------------------
package reg_seq_ctrl_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;
    localparam int PC_W   = 8;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_MOV  = 3'b101,
        OP_LDI  = 3'b110,
        OP_HALT = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        ST_F0   = 3'd0,
        ST_F1   = 3'd1,
        ST_F2   = 3'd2,
        ST_EXEC = 3'd3,
        ST_WB   = 3'd4,
        ST_HLT  = 3'd5
    } state_e;

    // byte0 = {OP, DST, 2'b00}
    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 5;
    localparam int DST_MSB = 4;
    localparam int DST_LSB = 2;
    // byte1 = {A, B, 2'b00}
    localparam int A_MSB   = 7;
    localparam int A_LSB   = 5;
    localparam int B_MSB   = 4;
    localparam int B_LSB   = 2;

    // Destination select 0 means "no register write".
    localparam logic [SEL_W-1:0] DSEL_NONE = 3'b000;
    // Operand select 0 routes DIN into the ALU instead of a register.
    localparam logic [SEL_W-1:0] SEL_DIN   = 3'b000;

    function automatic logic is_fetch(input state_e s);
        return (s == ST_F0) || (s == ST_F1) || (s == ST_F2);
    endfunction

endpackage

// File: rtl/reg_seq_ctrl_decode.sv
// -----------------------------------------------------------------------------
// instr_decode
// Purely combinational field extraction for the first two instruction bytes.
// Ports:
//   byte0    in  8  {OP, DST, reserved}
//   byte1    in  8  {A, B, reserved}
//   op       out 3  opcode
//   dst      out 3  destination register select
//   a, b     out 3  operand register selects
//   is_ldi   out 1  opcode is LDI (three-byte instruction)
//   is_halt  out 1  opcode is HALT
//   is_nop   out 1  opcode is NOP
// -----------------------------------------------------------------------------
module instr_decode
    import reg_seq_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] byte0,
    input  logic [DATA_W-1:0] byte1,
    output opcode_e           op,
    output logic [SEL_W-1:0]  dst,
    output logic [SEL_W-1:0]  a,
    output logic [SEL_W-1:0]  b,
    output logic              is_ldi,
    output logic              is_halt,
    output logic              is_nop
);

    // The two low bits of each byte are reserved and deliberately ignored.
    logic unused_reserved;
    assign unused_reserved = ^{byte0[1:0], byte1[1:0]};

    assign op      = opcode_e'(byte0[OP_MSB:OP_LSB]);
    assign dst     = byte0[DST_MSB:DST_LSB];
    assign a       = byte1[A_MSB:A_LSB];
    assign b       = byte1[B_MSB:B_LSB];
    assign is_ldi  = (op == OP_LDI);
    assign is_halt = (op == OP_HALT);
    assign is_nop  = (op == OP_NOP);

endmodule

// File: rtl/reg_seq_ctrl.sv
// -----------------------------------------------------------------------------
// reg_seq_ctrl
// Multi-cycle instruction sequencer. Fetches 2-byte (or 3-byte LDI)
// instructions over a request/ready handshake, then drives register-file
// selects, immediate and ALU opcode through an EXEC and a WB cycle.
// Ports:
//   CLK       in  1  clock, rising edge
//   RST       in  1  asynchronous active-high reset
//   MEM_REQ   out 1  fetch request, held until MEM_RDY
//   MEM_ADDR  out 8  fetch address (= PC)
//   MEM_RDY   in  1  memory accepts; MEM_DATA valid same cycle
//   MEM_DATA  in  8  fetched byte
//   ASEL      out 3  register-file A select (0 = DIN)
//   BSEL      out 3  register-file B select (0 = DIN)
//   DSEL      out 3  register-file write select (0 = no write)
//   DIN       out 8  immediate operand
//   ALU_OP    out 3  ALU operation
//   PC        out 8  address of next byte to fetch
//   HALT      out 1  high once HALT has executed
// Every output comes straight from a flop; MEM_RDY/MEM_DATA only reach
// the next-state logic.
// -----------------------------------------------------------------------------
module reg_seq_ctrl
    import reg_seq_ctrl_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    output logic              MEM_REQ,
    output logic [PC_W-1:0]   MEM_ADDR,
    input  logic              MEM_RDY,
    input  logic [DATA_W-1:0] MEM_DATA,
    output logic [SEL_W-1:0]  ASEL,
    output logic [SEL_W-1:0]  BSEL,
    output logic [SEL_W-1:0]  DSEL,
    output logic [DATA_W-1:0] DIN,
    output logic [SEL_W-1:0]  ALU_OP,
    output logic [PC_W-1:0]   PC,
    output logic              HALT
);

    state_e              state_reg,   state_next;
    logic [PC_W-1:0]     pc_reg,      pc_next;
    logic [DATA_W-1:0]   byte0_reg,   byte0_next;
    logic [DATA_W-1:0]   byte1_reg,   byte1_next;
    logic [DATA_W-1:0]   byte2_reg,   byte2_next;
    logic                mem_req_reg, mem_req_next;
    logic [SEL_W-1:0]    asel_reg,    asel_next;
    logic [SEL_W-1:0]    bsel_reg,    bsel_next;
    logic [SEL_W-1:0]    dsel_reg,    dsel_next;
    logic [SEL_W-1:0]    alu_op_reg,  alu_op_next;
    logic                halt_reg,    halt_next;

    logic                fetch_ack;
    logic [DATA_W-1:0]   dec_byte1;
    opcode_e             dec_op;
    logic [SEL_W-1:0]    dec_dst;
    logic [SEL_W-1:0]    dec_a;
    logic [SEL_W-1:0]    dec_b;
    logic                dec_is_ldi;
    logic                dec_is_halt;
    logic                dec_is_nop;

    // A byte is only taken when our own registered request is up, so a
    // stray MEM_RDY (e.g. the cycle right after reset) is ignored.
    assign fetch_ack = mem_req_reg && MEM_RDY;

    // In F1 the operand selects must be loaded on the same edge that
    // captures byte1, so decode the incoming byte rather than the register.
    assign dec_byte1 = (state_reg == ST_F1) ? MEM_DATA : byte1_reg;

    instr_decode u_decode (
        .byte0   (byte0_reg),
        .byte1   (dec_byte1),
        .op      (dec_op),
        .dst     (dec_dst),
        .a       (dec_a),
        .b       (dec_b),
        .is_ldi  (dec_is_ldi),
        .is_halt (dec_is_halt),
        .is_nop  (dec_is_nop)
    );

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        byte0_next  = byte0_reg;
        byte1_next  = byte1_reg;
        byte2_next  = byte2_reg;
        asel_next   = asel_reg;
        bsel_next   = bsel_reg;
        alu_op_next = alu_op_reg;
        dsel_next   = DSEL_NONE;

        case (state_reg)
            ST_F0: begin
                if (fetch_ack) begin
                    byte0_next = MEM_DATA;
                    pc_next    = pc_reg + 1'b1;
                    state_next = ST_F1;
                end
            end
            ST_F1: begin
                if (fetch_ack) begin
                    byte1_next = MEM_DATA;
                    pc_next    = pc_reg + 1'b1;
                    if (dec_is_nop) begin
                        state_next = ST_F0;
                    end else if (dec_is_halt) begin
                        state_next = ST_HLT;
                    end else if (dec_is_ldi) begin
                        state_next = ST_F2;
                    end else begin
                        state_next  = ST_EXEC;
                        asel_next   = dec_a;
                        bsel_next   = dec_b;
                        alu_op_next = dec_op;
                    end
                end
            end
            ST_F2: begin
                if (fetch_ack) begin
                    // LDI is executed as MOV of DIN through the ALU.
                    byte2_next  = MEM_DATA;
                    pc_next     = pc_reg + 1'b1;
                    state_next  = ST_EXEC;
                    asel_next   = SEL_DIN;
                    bsel_next   = SEL_DIN;
                    alu_op_next = OP_MOV;
                end
            end
            ST_EXEC: begin
                state_next = ST_WB;
                dsel_next  = dec_dst;
            end
            ST_WB: begin
                state_next = ST_F0;
            end
            ST_HLT: begin
                state_next = ST_HLT;
            end
            default: begin
                state_next = ST_F0;
            end
        endcase

        // Request/halt flags follow the state being entered so they are
        // valid from the first cycle of that state.
        mem_req_next = is_fetch(state_next);
        halt_next    = (state_next == ST_HLT);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg   <= ST_F0;
            pc_reg      <= '0;
            byte0_reg   <= '0;
            byte1_reg   <= '0;
            byte2_reg   <= '0;
            mem_req_reg <= 1'b0;
            asel_reg    <= '0;
            bsel_reg    <= '0;
            dsel_reg    <= DSEL_NONE;
            alu_op_reg  <= '0;
            halt_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            byte0_reg   <= byte0_next;
            byte1_reg   <= byte1_next;
            byte2_reg   <= byte2_next;
            mem_req_reg <= mem_req_next;
            asel_reg    <= asel_next;
            bsel_reg    <= bsel_next;
            dsel_reg    <= dsel_next;
            alu_op_reg  <= alu_op_next;
            halt_reg    <= halt_next;
        end
    end

    assign MEM_REQ  = mem_req_reg;
    assign MEM_ADDR = pc_reg;
    assign PC       = pc_reg;
    assign ASEL     = asel_reg;
    assign BSEL     = bsel_reg;
    assign DSEL     = dsel_reg;
    // The immediate register doubles as the DIN output register.
    assign DIN      = byte2_reg;
    assign ALU_OP   = alu_op_reg;
    assign HALT     = halt_reg;

endmodule

// File: tb/tb_reg_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_seq_ctrl
// Builds an expected per-cycle output trace from a program image at the
// instruction level (byte counts, wait cycles, EXEC/WB pair), then replays
// it against the sequencer while acting as program memory.
// -----------------------------------------------------------------------------
module tb_reg_seq_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       MEM_REQ;
    logic [7:0] MEM_ADDR;
    logic       MEM_RDY = 1'b0;
    logic [7:0] MEM_DATA = 8'h00;
    logic [2:0] ASEL, BSEL, DSEL, ALU_OP;
    logic [7:0] DIN, PC;
    logic       HALT;

    always #5 CLK = ~CLK;

    reg_seq_ctrl dut (
        .CLK      (CLK),
        .RST      (RST),
        .MEM_REQ  (MEM_REQ),
        .MEM_ADDR (MEM_ADDR),
        .MEM_RDY  (MEM_RDY),
        .MEM_DATA (MEM_DATA),
        .ASEL     (ASEL),
        .BSEL     (BSEL),
        .DSEL     (DSEL),
        .DIN      (DIN),
        .ALU_OP   (ALU_OP),
        .PC       (PC),
        .HALT     (HALT)
    );

    typedef struct packed {
        logic       req;
        logic [7:0] addr;
        logic [2:0] dsel;
        logic [2:0] asel;
        logic [2:0] bsel;
        logic [7:0] din;
        logic [2:0] op;
        logic [7:0] pc;
        logic       halt;
    } obs_t;

    typedef struct packed {
        logic rdy;
        obs_t o;
    } cyc_t;

    cyc_t       exp_q[$];
    logic [7:0] mem [256];
    int         m_pc;
    logic [2:0] m_asel, m_bsel, m_op;
    logic [7:0] m_din;
    int         total = 0;
    int         bad   = 0;
    int         cyc_n = 0;

    // ---------------- reference model (instruction level) ----------------
    task automatic model_reset();
        m_pc = 0; m_asel = 3'd0; m_bsel = 3'd0; m_op = 3'd0; m_din = 8'd0;
        exp_q.delete();
    endtask

    task automatic push(input logic req, input logic rdy,
                        input logic [2:0] dsel, input logic halt);
        cyc_t c;
        c.rdy    = rdy;
        c.o.req  = req;
        c.o.addr = 8'(m_pc);
        c.o.dsel = dsel;
        c.o.asel = m_asel;
        c.o.bsel = m_bsel;
        c.o.din  = m_din;
        c.o.op   = m_op;
        c.o.pc   = 8'(m_pc);
        c.o.halt = halt;
        exp_q.push_back(c);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One byte fetch: 'waits' cycles of refused request, then acceptance.
    task automatic fetch(input int waits, output logic [7:0] data);
        for (int w = 0; w < waits; w++) push(1'b1, 1'b0, 3'd0, 1'b0);
        push(1'b1, 1'b1, 3'd0, 1'b0);
        data = mem[m_pc];
        m_pc = (m_pc + 1) % 256;
    endtask

    task automatic gen_instr(input int w0, input int w1, input int w2);
        logic [7:0] b0, b1, imm;
        logic [2:0] op, dst;
        int         pc0;
        pc0 = m_pc;
        fetch(w0, b0);
        fetch(w1, b1);
        op  = b0[7:5];
        dst = b0[4:2];
        $display("instr @%02h op=%0d dst=%0d a=%0d b=%0d", pc0, op, dst, b1[7:5], b1[4:2]);
        if (op == 3'd0 || op == 3'd7) return;
        if (op == 3'd6) begin
            fetch(w2, imm);
            m_din = imm; m_asel = 3'd0; m_bsel = 3'd0; m_op = 3'd5;
        end else begin
            m_asel = b1[7:5]; m_bsel = b1[4:2]; m_op = op;
        end
        push(1'b0, rbit(), 3'd0, 1'b0);   // EXEC
        push(1'b0, rbit(), dst, 1'b0);    // WB
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) push(1'b0, rbit(), 3'd0, 1'b1);
    endtask

    // ---------------- checking / driving ----------------
    task automatic check_obs(input string tag, input obs_t e);
        obs_t got;
        got = {MEM_REQ, MEM_ADDR, DSEL, ASEL, BSEL, DIN, ALU_OP, PC, HALT};
        total++;
        assert (got === e) else begin
            bad++;
            $error("FAIL %s got=%h expected=%h", tag, got, e);
        end
    endtask

    task automatic run_trace(input int leave);
        cyc_t c;
        while (exp_q.size() > leave) begin
            @(negedge CLK);
            c = exp_q.pop_front();
            cyc_n++;
            check_obs($sformatf("cyc%0d", cyc_n), c.o);
            MEM_RDY  = c.rdy;
            MEM_DATA = (c.o.req && c.rdy) ? mem[c.o.addr] : 8'($urandom);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge CLK);
        RST = 1'b1;
        MEM_RDY = 1'b0;
        #1 check_obs({tag, "_async"}, '0);
        @(negedge CLK);
        check_obs({tag, "_hold"}, '0);
        RST = 1'b0;
        model_reset();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc_t c;
        foreach (mem[i]) mem[i] = 8'($urandom);
        model_reset();
        do_reset("rst0");

        // ADD r1 <- r2 op r2, zero-wait
        mem[0] = 8'h24; mem[1] = 8'h48;
        gen_instr(0, 0, 0);
        run_trace(0);
        do_reset("rst1");

        // LDI r2 <- 0x5A
        mem[0] = 8'hC8; mem[1] = 8'h00; mem[2] = 8'h5A;
        gen_instr(0, 0, 0);
        run_trace(0);
        do_reset("rst2");

        // ADD with three wait cycles on byte1
        mem[0] = 8'h24; mem[1] = 8'h48;
        gen_instr(0, 3, 0);
        run_trace(0);
        do_reset("rst3");

        // NOP then HALT, then stay halted
        mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'hE0; mem[3] = 8'h00;
        gen_instr(0, 0, 0);
        gen_instr(0, 0, 0);
        halt_cycles(20);
        run_trace(0);
        do_reset("rst4");

        // PC wrap: LDI + 126 NOPs puts an ADD at 0xFF, byte1 from 0x00
        mem[0] = 8'hC8; mem[1] = 8'($urandom); mem[2] = 8'($urandom);
        for (int i = 3; i < 255; i++) mem[i] = 8'($urandom) & 8'h1F;
        mem[255] = 8'h24;
        gen_instr(0, 0, 0);
        for (int i = 0; i < 126; i++)
            gen_instr($urandom_range(0, 1), $urandom_range(0, 1), 0);
        gen_instr(0, 0, 0);
        run_trace(0);
        do_reset("rst5");

        // Random program (HALT opcodes remapped to LDI), random waits
        foreach (mem[i]) begin
            mem[i] = 8'($urandom);
            if (mem[i] >= 8'hE0) mem[i] = mem[i] & 8'hDF;
        end
        for (int i = 0; i < 40; i++)
            gen_instr($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
        run_trace(0);
        do_reset("rst6");

        // Reset asserted in the middle of WB
        mem[0] = 8'h3C; mem[1] = 8'h6C;
        gen_instr(0, 0, 0);
        run_trace(1);
        @(negedge CLK);
        c = exp_q.pop_front();
        check_obs("wb_pre_rst", c.o);
        #2 RST = 1'b1;
        #1 check_obs("wb_rst_async", '0);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        gen_instr(0, 0, 0);
        run_trace(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
